alu_op_sequencer: RTL

- Control and operand stage wrapped around the 32-bit ALU.
- Accepts one ALU operation per handshake and reads both operands from a local 4×32 register bank (B may be an immediate).
- Drives the ALU's A, B, FunSel and WF for exactly one cycle, then captures ALUOut and writes it back to a destination register.
- Feeds the ALU and consumes its output and flags; supports flag-conditional execution.

---
 rtl/alu_pkg.sv | 69 ++++++
 rtl/alu_op_sequencer_seq_reg_bank.sv | 38 +++
 rtl/alu_op_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: widths, ALU opcodes,
// flag bit positions, condition codes, FSM encoding and the latched-op payload.
package alu_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NUM_REGS = 4;
   localparam int unsigned ADDR_W   = 2;
   localparam int unsigned FUNSEL_W = 5;
   localparam int unsigned FLAGS_W  = 4;
   localparam int unsigned IMM_W    = 16;
   localparam int unsigned COND_W   = 2;

   // ALU opcodes carried in FunSel[3:0]; FunSel[4] selects operand width
   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0111;
   localparam logic [3:0] ALU_OR  = 4'b1000;
   localparam logic [3:0] ALU_XOR = 4'b1001;

   // Bit positions inside the ALU flag vector {Z,C,N,O}
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_O = 0;

   typedef enum logic [COND_W-1:0] {
      COND_ALWAYS = 2'b00,
      COND_Z      = 2'b01,
      COND_NZ     = 2'b10,
      COND_N      = 2'b11
   } cond_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   // Operation fields captured at the accept handshake
   typedef struct packed {
      logic [FUNSEL_W-1:0] fun_sel;
      logic [ADDR_W-1:0]   dst;
      logic [ADDR_W-1:0]   src_a;
      logic [ADDR_W-1:0]   src_b;
      logic                b_sel;
      logic [IMM_W-1:0]    imm;
      logic                wf;
      cond_e               cond;
   } op_t;

   // True when the condition code is satisfied by the given flag vector
   function automatic logic cond_met(input cond_e cond, input logic [FLAGS_W-1:0] flags);
      logic ok;
      ok = 1'b1;
      case (cond)
         COND_ALWAYS: ok = 1'b1;
         COND_Z:      ok = flags[FLAG_Z];
         COND_NZ:     ok = ~flags[FLAG_Z];
         COND_N:      ok = flags[FLAG_N];
         default:     ok = 1'b1;
      endcase
      return ok;
   endfunction

   function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/alu_op_sequencer_seq_reg_bank.sv
// 4x32 operand register bank for the sequencer.
// Ports: clk/rst (sync, active-high), one write port (we/waddr/wdata),
//        two async operand read ports (raddr_a/b -> rdata_a/b) and an
//        async debug read port (raddr_dbg -> rdata_dbg).
module seq_reg_bank
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   input  logic [ADDR_W-1:0] raddr_dbg,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic [DATA_W-1:0] rdata_dbg
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   // Storage: reset clears every entry, otherwise single write port
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a   = mem[raddr_a];
   assign rdata_b   = mem[raddr_b];
   assign rdata_dbg = mem[raddr_dbg];

endmodule

// File: rtl/alu_op_sequencer.sv
// Control and operand stage around the 32-bit ALU. Accepts one operation per
// handshake, presents operands/FunSel/WF to the ALU for exactly one cycle
// (EXEC), captures ALUOut, and writes it back in WB if the flag condition held.
// Ports:
//   Clock, Reset                 - clock, sync active-high reset
//   InValid/InReady + In* fields - operation request handshake
//   ALU_A/ALU_B/ALU_FunSel/ALU_WF - ALU drive, non-zero only in EXEC
//   ALUOut, FlagsIn              - ALU result and flags {Z,C,N,O}
//   LoadEn/LoadAddr/LoadData     - direct bank load, honoured in IDLE only
//   RdAddr/RdData                - combinational debug read
//   Done/Skipped                 - retire pulse and condition-failed marker
module alu_op_sequencer
   import alu_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                InValid,
   output logic                InReady,
   input  logic [FUNSEL_W-1:0] InFunSel,
   input  logic [ADDR_W-1:0]   InDst,
   input  logic [ADDR_W-1:0]   InSrcA,
   input  logic [ADDR_W-1:0]   InSrcB,
   input  logic                InBSel,
   input  logic [IMM_W-1:0]    InImm,
   input  logic                InWF,
   input  logic [COND_W-1:0]   InCond,
   output logic [DATA_W-1:0]   ALU_A,
   output logic [DATA_W-1:0]   ALU_B,
   output logic [FUNSEL_W-1:0] ALU_FunSel,
   output logic                ALU_WF,
   input  logic [DATA_W-1:0]   ALUOut,
   input  logic [FLAGS_W-1:0]  FlagsIn,
   input  logic                LoadEn,
   input  logic [ADDR_W-1:0]   LoadAddr,
   input  logic [DATA_W-1:0]   LoadData,
   input  logic [ADDR_W-1:0]   RdAddr,
   output logic [DATA_W-1:0]   RdData,
   output logic                Done,
   output logic                Skipped
);

   state_e            state_q, state_d;
   op_t               op_q, op_in;
   logic [DATA_W-1:0] result_q;
   logic              cond_ok_q;
   logic              cond_ok;
   logic              accept;

   logic              bank_we;
   logic [ADDR_W-1:0] bank_waddr;
   logic [DATA_W-1:0] bank_wdata;
   logic [DATA_W-1:0] rdata_a, rdata_b;

   always_comb begin
      op_in = '{fun_sel: InFunSel,
                dst:     InDst,
                src_a:   InSrcA,
                src_b:   InSrcB,
                b_sel:   InBSel,
                imm:     InImm,
                wf:      InWF,
                cond:    cond_e'(InCond)};
   end

   // Flags seen during EXEC belong to the previous op, since WF is low elsewhere
   assign cond_ok = cond_met(op_q.cond, FlagsIn);

   seq_reg_bank u_bank (
      .clk       (Clock),
      .rst       (Reset),
      .we        (bank_we),
      .waddr     (bank_waddr),
      .wdata     (bank_wdata),
      .raddr_a   (op_q.src_a),
      .raddr_b   (op_q.src_b),
      .raddr_dbg (RdAddr),
      .rdata_a   (rdata_a),
      .rdata_b   (rdata_b),
      .rdata_dbg (RdData)
   );

   // FSM state register
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched op, captured result and condition outcome
   always_ff @(posedge Clock) begin
      if (Reset) begin
         op_q      <= '0;
         result_q  <= '0;
         cond_ok_q <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= op_in;
         end
         if (state_q == ST_EXEC) begin
            result_q  <= ALUOut;
            cond_ok_q <= cond_ok;
         end
      end
   end

   // Next state, ALU drive, bank write port mux and retire outputs
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      InReady    = 1'b0;
      ALU_A      = '0;
      ALU_B      = '0;
      ALU_FunSel = '0;
      ALU_WF     = 1'b0;
      Done       = 1'b0;
      Skipped    = 1'b0;
      bank_we    = 1'b0;
      bank_waddr = LoadAddr;
      bank_wdata = LoadData;

      case (state_q)
         ST_IDLE: begin
            InReady = 1'b1;
            bank_we = LoadEn;
            if (InValid) begin
               accept  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            ALU_A      = rdata_a;
            ALU_B      = op_q.b_sel ? sext_imm(op_q.imm) : rdata_b;
            ALU_FunSel = op_q.fun_sel;
            ALU_WF     = op_q.wf & cond_ok;
            state_d    = ST_WB;
         end
         ST_WB: begin
            // A reset arriving in WB aborts the retire entirely
            Done       = ~Reset;
            Skipped    = ~Reset & ~cond_ok_q;
            bank_we    = cond_ok_q;
            bank_waddr = op_q.dst;
            bank_wdata = result_q;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
